// File: rtl/calc_result_display.sv
// calc_result_display: accepts an 8-bit calculator result plus error flag,
// converts it to 3-digit BCD by sequential double-dabble (one bit per cycle),
// holds the last completed value and scans it onto a 3-digit seven-segment
// display with leading-zero blanking and an "Err" override.
module calc_result_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  result,
  input  logic        error,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        err_latched,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [1:0]        state;
  logic [3:0]        iter;
  logic [7:0]        bin;
  logic [11:0]       sh;
  logic [11:0]       sh_adj;
  logic [11:0]       sh_next;
  logic [7:0]        bin_next;
  logic              xfer;
  logic [SCAN_W-1:0] scan_cnt;
  logic [6:0]        seg_ones;
  logic [6:0]        seg_tens;
  logic [6:0]        seg_hund;

  // Double-dabble correction: 4-bit add-3 on nibbles >= 5, carry-out dropped.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Digit-to-segment encoding, bit0 = segment a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign xfer     = in_valid && in_ready;

  // One double-dabble iteration: correct nibbles, then shift {bcd,bin} left.
  always_comb begin
    sh_adj = {add3(sh[11:8]), add3(sh[7:4]), add3(sh[3:0])};
    {sh_next, bin_next} = {sh_adj, bin} << 1;
  end

  // Control FSM and held display state; the held value is updated on the
  // edge that enters DONE so bcd, bcd_valid and seg change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      iter        <= 4'd0;
      bcd         <= 12'h000;
      bcd_valid   <= 1'b0;
      err_latched <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (error) begin
              state       <= S_DONE;
              err_latched <= 1'b1;
              bcd_valid   <= 1'b1;
            end else begin
              state <= S_SHIFT;
              iter  <= 4'd8;
            end
          end
        end
        S_SHIFT: begin
          iter <= iter - 4'd1;
          if (iter == 4'd1) begin
            state       <= S_DONE;
            bcd         <= sh_next;
            err_latched <= 1'b0;
            bcd_valid   <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Conversion datapath: load on transfer, iterate while shifting.
  always_ff @(posedge clk) begin
    if (xfer) begin
      bin <= result;
      sh  <= 12'h000;
    end else if (state == S_SHIFT) begin
      bin <= bin_next;
      sh  <= sh_next;
    end
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      an       <= 3'b001;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      an       <= {an[1:0], an[2]};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Per-digit patterns with leading-zero blanking and the "Err" override.
  always_comb begin
    if (err_latched) begin
      seg_hund = 7'h79;
      seg_tens = 7'h50;
      seg_ones = 7'h50;
    end else begin
      seg_hund = (bcd[11:8] == 4'd0) ? 7'h00 : seg7(bcd[11:8]);
      seg_tens = (bcd[11:4] == 8'd0) ? 7'h00 : seg7(bcd[7:4]);
      seg_ones = seg7(bcd[3:0]);
    end
  end

  // Select the pattern for the currently enabled digit.
  always_comb begin
    case (an)
      3'b001:  seg = seg_ones;
      3'b010:  seg = seg_tens;
      3'b100:  seg = seg_hund;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display: the driver pushes the expected
// BCD, error flag and DONE cycle per accepted transfer; a monitor pops and
// compares whenever bcd_valid pulses.
module tb_calc_result_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  result = 8'd0;
  logic        error = 1'b0;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        err_latched;
  logic [6:0]  seg;
  logic [2:0]  an;

  typedef struct packed {
    logic [11:0] bcd;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  calc_result_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .error(error), .bcd(bcd), .bcd_valid(bcd_valid),
    .err_latched(err_latched), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every bcd_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bcd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bcd_valid: got bcd=%0h with no pending transfer (cycle %0d)", bcd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_bcd", 32'(bcd), 32'(e.bcd));
        check("sb_err", 32'(err_latched), 32'(e.err));
        check("sb_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  // Issue one transfer; n returns the cycle in which it was presented.
  task automatic send(input logic [7:0] r, input logic e, input logic [11:0] eb,
                      input bit push, output int n);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 expected 1 after %0d cycles", w);
    end
    in_valid = 1'b1;
    result   = r;
    error    = e;
    n        = cyc;
    if (push) exp_q.push_back('{eb, e, 32'(n + (e ? 1 : 9))});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Visit each digit position and compare its segment pattern.
  task automatic check_seg(input logic [6:0] s_ones, input logic [6:0] s_tens, input logic [6:0] s_hund);
    logic [2:0] tgt [3];
    logic [6:0] req [3];
    tgt[0] = 3'b001; tgt[1] = 3'b010; tgt[2] = 3'b100;
    req[0] = s_ones; req[1] = s_tens; req[2] = s_hund;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (an !== tgt[k] && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (an !== tgt[k]) begin
        total++;
        bad++;
        $display("FAIL scan_timeout: an=%b expected %b", an, tgt[k]);
      end else begin
        check($sformatf("seg_an%b", tgt[k]), 32'(seg), 32'(req[k]));
      end
    end
  endtask

  initial begin
    int n;

    // 1: reset mid-scan, then scan period
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'h1);
    check("rst_seg", 32'(seg), 32'h3F);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_bcd", 32'(bcd), 32'h000);
    check("rst_err", 32'(err_latched), 32'd0);
    check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("scan_hold_3", 32'(an), 32'h1);
    @(posedge clk);
    #1 check("scan_step_4", 32'(an), 32'h2);
    repeat (4) @(posedge clk);
    #1 check("scan_step_8", 32'(an), 32'h4);

    // 2: 255, busy window and display
    send(8'd255, 1'b0, 12'h255, 1'b1, n);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("busy_N+%0d", k), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("ready_N+10", 32'(in_ready), 32'd1);
    drain();
    check_seg(7'h6D, 7'h6D, 7'h5B);

    // 3: 7 then 105 (inner zero shown)
    send(8'd7, 1'b0, 12'h007, 1'b1, n);
    drain();
    check_seg(7'h07, 7'h00, 7'h00);
    send(8'd105, 1'b0, 12'h105, 1'b1, n);
    drain();
    check_seg(7'h6D, 7'h3F, 7'h06);

    // 4: divide-by-zero then recovery
    send(8'd0, 1'b1, 12'h105, 1'b1, n);
    drain();
    check_seg(7'h50, 7'h50, 7'h79);
    send(8'd42, 1'b0, 12'h042, 1'b1, n);
    drain();
    check("err_cleared", 32'(err_latched), 32'd0);
    check_seg(7'h5B, 7'h66, 7'h00);

    // 5: in_valid held with 200 while 13 converts
    @(negedge clk);
    in_valid = 1'b1;
    result   = 8'd13;
    error    = 1'b0;
    n        = cyc;
    exp_q.push_back('{12'h013, 1'b0, 32'(n + 9)});
    exp_q.push_back('{12'h200, 1'b0, 32'(n + 19)});
    @(posedge clk);
    #1 result = 8'd200;
    while (cyc < n + 11) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    check("bcd_200", 32'(bcd), 32'h200);

    // 6: reset in the 4th shift cycle of 99
    send(8'd99, 1'b0, 12'h000, 1'b0, n);
    while (cyc < n + 4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd), 32'h000);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_an", 32'(an), 32'h1);
    check("abort_seg", 32'(seg), 32'h3F);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_update", 32'(bcd), 32'h000);
    send(8'd99, 1'b0, 12'h099, 1'b1, n);
    drain();
    check_seg(7'h6F, 7'h6F, 7'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
